// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage and its queue.
// Word addresses are bits [15:1] of the byte address.
package fetch_pkg;

  localparam int ADDR_W = 15;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W:1] addr_t;

  typedef struct packed {
    addr_t              pc;
    addr_t              pred;
    logic [INSTR_W-1:0] instr;
    logic               filled;
    logic               kill;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: alloc on issue, fill on response,
// pop at the head; kill_all marks every entry wrong-path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc,
  input  addr_t              alloc_pc,
  input  addr_t              alloc_pred,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop,
  input  logic               kill_all,
  output logic [PW:0]        count,
  output logic               full,
  output fq_entry_t          head
);

  fq_entry_t   q [DEPTH];
  logic [PW:0] alloc_ptr;
  logic [PW:0] fill_ptr;
  logic [PW:0] rd_ptr;
  logic        pending;

  // Pointers carry a wrap bit so full and empty differ.
  assign count   = alloc_ptr - rd_ptr;
  assign full    = count == (PW + 1)'(DEPTH);
  assign pending = fill_ptr != alloc_ptr;
  assign head    = q[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (kill_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          q[i].kill <= 1'b1;
        end
      end
      if (alloc) begin
        q[alloc_ptr[PW-1:0]] <= '{
          pc:     alloc_pc,
          pred:   alloc_pred,
          instr:  '0,
          filled: 1'b0,
          kill:   1'b0
        };
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill && pending) begin
        q[fill_ptr[PW-1:0]].instr  <= fill_instr;
        q[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A response with nothing outstanding is dropped.
  rsp_has_slot: assert property (
    @(posedge clk) disable iff (!rst_n)
    fill |-> pending
  );

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, issue, redirect and predictor write-back.
// Define FETCH_PERF_EN to add redirect/stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:1] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:1] bp_raddr,
  input  logic [15:1] bp_rdata,
  output logic        bp_wen,
  output logic [15:1] bp_waddr,
  output logic [15:1] bp_wdata,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:1] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [15:1] redirect_src_pc,
  input  logic [15:1] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:1] out_pc,
  output logic [15:1] out_pred_pc,
  output logic [15:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);

  addr_t       pc;
  logic        run;
  logic [PW:0] count;
  logic        full;
  logic        empty;
  fq_entry_t   head;
  logic        fire;
  logic        drop;
  logic        pop;

  assign bp_raddr      = pc;
  assign imem_req_addr = pc;

  // run keeps issue quiet through the reset cycle.
  assign imem_req_valid =
    run && !full && !redirect_valid;
  assign fire = imem_req_valid && imem_req_ready;

  assign empty = count == '0;
  assign out_valid =
    !empty && head.filled && !head.kill &&
    !redirect_valid;
  assign drop = !empty && head.filled && head.kill;
  assign pop  = (out_valid && out_ready) || drop;

  assign out_pc      = head.pc;
  assign out_pred_pc = head.pred;
  assign out_instr   = head.instr;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc      (fire),
    .alloc_pc   (pc),
    .alloc_pred (bp_rdata),
    .fill       (imem_rsp_valid),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .kill_all   (redirect_valid),
    .count      (count),
    .full       (full),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      run      <= 1'b0;
      bp_wen   <= 1'b0;
      bp_waddr <= '0;
      bp_wdata <= '0;
    end else begin
      run    <= 1'b1;
      bp_wen <= redirect_valid;
      if (redirect_valid) begin
        pc       <= redirect_target;
        bp_waddr <= redirect_src_pc;
        bp_wdata <= redirect_target;
      end else if (fire) begin
        pc <= bp_rdata;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect_valid) begin
        perf_redirects <= perf_redirects + 1'b1;
      end
      if (full) begin
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction model of the fetch path
// plus directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [15:1] bp_raddr, bp_rdata, bp_waddr, bp_wdata;
  logic        bp_wen;
  logic        imem_req_valid, imem_req_ready;
  logic [15:1] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:1] redirect_src_pc, redirect_target;
  logic        out_valid, out_ready;
  logic [15:1] out_pc, out_pred_pc;
  logic [15:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects, perf_stall_cycles;
  logic [31:0] w_perf_r, w_perf_s;
`endif

  logic [15:1] tab [32768];
  assign bp_rdata = tab[bp_raddr];

  fetch_stage #(
    .DEPTH    (4),
    .RESET_PC (15'h0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bp_raddr        (bp_raddr),
    .bp_rdata        (bp_rdata),
    .bp_wen          (bp_wen),
    .bp_waddr        (bp_waddr),
    .bp_wdata        (bp_wdata),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_src_pc (redirect_src_pc),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_pred_pc     (out_pred_pc),
    .out_instr       (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Second instance starting near the top of the PC space.
  logic [15:1] w_raddr, w_rdata, w_waddr, w_wdata;
  logic        w_wen, w_req_valid, w_req_ready;
  logic [15:1] w_req_addr;
  logic        w_rsp_valid;
  logic [15:0] w_rsp_data;
  logic        w_rd_valid;
  logic [15:1] w_rd_src, w_rd_tgt;
  logic        w_out_valid, w_out_ready;
  logic [15:1] w_out_pc, w_out_pred;
  logic [15:0] w_out_instr;

  assign w_rdata     = w_raddr + 15'd1;
  assign w_req_ready = 1'b1;
  assign w_out_ready = 1'b1;
  assign w_rd_valid  = 1'b0;
  assign w_rd_src    = '0;
  assign w_rd_tgt    = '0;

  fetch_stage #(
    .DEPTH    (4),
    .RESET_PC (15'h7ffe)
  ) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .bp_raddr        (w_raddr),
    .bp_rdata        (w_rdata),
    .bp_wen          (w_wen),
    .bp_waddr        (w_waddr),
    .bp_wdata        (w_wdata),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_rsp_valid  (w_rsp_valid),
    .imem_rsp_data   (w_rsp_data),
    .redirect_valid  (w_rd_valid),
    .redirect_src_pc (w_rd_src),
    .redirect_target (w_rd_tgt),
    .out_valid       (w_out_valid),
    .out_ready       (w_out_ready),
    .out_pc          (w_out_pc),
    .out_pred_pc     (w_out_pred),
    .out_instr       (w_out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects    (w_perf_r),
    .perf_stall_cycles (w_perf_s)
`endif
  );

  logic [15:1] w_hist [$];
  logic        w_fire_q = 1'b0;
  logic [15:1] w_addr_q = '0;

  initial begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    forever begin
      @(negedge clk);
      w_rsp_valid = w_fire_q && rst_n;
      w_rsp_data  = {1'b0, w_addr_q};
      #1;
      w_fire_q = rst_n && w_req_valid;
      w_addr_q = w_req_addr;
      if (rst_n && w_out_valid && w_hist.size() < 3)
        w_hist.push_back(w_out_pc);
    end
  end

  typedef struct {
    logic [15:1] pc;
    logic [15:1] pred;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } mem_t;

  int n_chk = 0;
  int n_fail = 0;

  exp_t        exp_q [$];
  mem_t        mq [$];
  logic [15:1] hp [$];
  logic [15:1] hpred [$];
  int          hc [$];
  logic [15:1] fa [$];
  int          fc [$];

  logic [15:1] model_pc;
  int          cyc;
  int          last_due;
  logic        pend_wen;
  logic [15:1] pend_src, pend_tgt;
  logic        s_wen, s_req_valid;
  logic [15:1] s_waddr, s_wdata;
  logic [15:1] s_req_addr, s_raddr;

  int lat_lo, lat_hi, rdy_pct, ordy_pct, rd_pct;
  logic        force_rd = 1'b0;
  logic [15:1] f_src, f_tgt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    int   due;
    @(negedge clk);
    imem_req_ready = $urandom_range(99) < rdy_pct;
    out_ready      = $urandom_range(99) < ordy_pct;
    if (force_rd) begin
      redirect_valid  = 1'b1;
      redirect_src_pc = f_src;
      redirect_target = f_tgt;
      force_rd        = 1'b0;
    end else if ($urandom_range(99) < rd_pct) begin
      redirect_valid  = 1'b1;
      redirect_src_pc = 15'($urandom);
      redirect_target = 15'($urandom);
    end else begin
      redirect_valid = 1'b0;
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].d;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'($urandom);
    end
    #1;
    chk("bp_wen", bp_wen, pend_wen);
    if (pend_wen) begin
      chk("bp_waddr", bp_waddr, pend_src);
      chk("bp_wdata", bp_wdata, pend_tgt);
    end
    s_wen       = bp_wen;
    s_waddr     = bp_waddr;
    s_wdata     = bp_wdata;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_raddr     = bp_raddr;
    if (redirect_valid) begin
      chk("req_in_redirect", imem_req_valid, 0);
      chk("out_in_redirect", out_valid, 0);
    end
    if (out_valid && out_ready) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_pred", out_pred_pc, e.pred);
        chk("out_instr", out_instr, {1'b0, e.pc});
      end
      hp.push_back(out_pc);
      hpred.push_back(out_pred_pc);
      hc.push_back(cyc);
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, model_pc);
      chk("bp_raddr", bp_raddr, model_pc);
      exp_q.push_back('{pc: model_pc, pred: tab[model_pc]});
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due: due, d: {1'b0, model_pc}});
      fa.push_back(imem_req_addr);
      fc.push_back(cyc);
      model_pc = tab[model_pc];
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_target;
    end
    pend_wen = redirect_valid;
    pend_src = redirect_src_pc;
    pend_tgt = redirect_target;
    @(posedge clk);
    if (s_wen) tab[s_waddr] = s_wdata;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_bp_wen", bp_wen, 0);
    chk("rst_bp_waddr", bp_waddr, 0);
    chk("rst_bp_wdata", bp_wdata, 0);
    chk("rst_pc", bp_raddr, 15'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    exp_q.delete();
    hp.delete();
    hpred.delete();
    hc.delete();
    fa.delete();
    fc.delete();
    model_pc = 15'h0000;
    pend_wen = 1'b0;
    last_due = -1;
    cyc      = 0;
  endtask

  task automatic knobs(input int lo, input int hi,
                       input int rdy, input int ordy,
                       input int rd);
    lat_lo   = lo;
    lat_hi   = hi;
    rdy_pct  = rdy;
    ordy_pct = ordy;
    rd_pct   = rd;
  endtask

  initial begin
    int n0;
    int rc;
    for (int i = 0; i < 32768; i++) tab[i] = 15'(i + 1);
    redirect_src_pc = '0;
    redirect_target = '0;
    knobs(1, 1, 100, 100, 0);

    // Streaming from reset with a 1-cycle memory.
    do_reset();
    repeat (8) step();
    chk("a_hand_cnt", hp.size() >= 4, 1);
    if (hp.size() >= 4 && fc.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        chk("a_out_pc", hp[k], 15'(k));
        chk("a_pred", hpred[k], 15'(k + 1));
        chk("a_no_bubble", hc[k] - hc[0], k);
      end
      chk("a_latency", hc[0] - fc[0], 2);
    end

    // Wrap-around instance.
    chk("w_cnt", w_hist.size(), 3);
    if (w_hist.size() == 3) begin
      chk("w_pc0", w_hist[0], 15'h7ffe);
      chk("w_pc1", w_hist[1], 15'h7fff);
      chk("w_pc2", w_hist[2], 15'h0000);
    end

    // Decode stalled: queue fills, then drains.
    do_reset();
    knobs(1, 1, 100, 0, 0);
    repeat (10) step();
    chk("c_fires", fa.size(), 4);
    chk("c_req_full", s_req_valid, 0);
    chk("c_no_hand", hp.size(), 0);
    ordy_pct = 100;
    repeat (6) step();
    chk("c_hand_cnt", hp.size() >= 4, 1);
    chk("c_fire_cnt", fa.size() >= 5, 1);
    if (hp.size() >= 4 && fa.size() >= 5) begin
      for (int k = 0; k < 4; k++)
        chk("c_out_pc", hp[k], 15'(k));
      chk("c_resume", fa[4], 15'h0004);
    end

    // Memory not ready: PC holds.
    do_reset();
    knobs(1, 1, 100, 100, 0);
    repeat (3) step();
    rdy_pct = 0;
    n0 = fa.size();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("d_req_addr", s_req_addr, 15'h0003);
      chk("d_raddr", s_raddr, 15'h0003);
      chk("d_req_valid", s_req_valid, 1);
    end
    chk("d_no_alloc", fa.size(), n0);

    // Redirect and predictor write-back.
    do_reset();
    knobs(1, 1, 100, 100, 0);
    repeat (8) step();
    f_src = 15'h0005;
    f_tgt = 15'h0100;
    force_rd = 1'b1;
    step();
    n0 = hp.size();
    step();
    chk("b_wen", s_wen, 1);
    chk("b_waddr", s_waddr, 15'h0005);
    chk("b_wdata", s_wdata, 15'h0100);
    for (int k = 0; k < 20 && hp.size() <= n0; k++)
      step();
    chk("b_hand", hp.size() > n0, 1);
    if (hp.size() > n0)
      chk("b_first_pc", hp[n0], 15'h0100);
    f_src = 15'h01ff;
    f_tgt = 15'h0005;
    force_rd = 1'b1;
    step();
    n0 = hp.size();
    for (int k = 0; k < 20 && hp.size() <= n0; k++)
      step();
    chk("b_hand2", hp.size() > n0, 1);
    if (hp.size() > n0) begin
      chk("b_pc5", hp[n0], 15'h0005);
      chk("b_pred5", hpred[n0], 15'h0100);
    end

    // Redirect over three slow outstanding fetches.
    do_reset();
    knobs(3, 3, 100, 100, 0);
    repeat (3) step();
    chk("e_outstanding", mq.size(), 3);
    f_src = 15'h0300;
    f_tgt = 15'h0200;
    force_rd = 1'b1;
    rc = cyc;
    step();
    for (int k = 0; k < 20 && hp.size() == 0; k++)
      step();
    chk("e_hand", hp.size() > 0, 1);
    if (hp.size() > 0) begin
      chk("e_pc", hp[0], 15'h0200);
      chk("e_delay", hc[0] - rc, 5);
    end

    // Randomized soak, then drain.
    do_reset();
    knobs(1, 3, 70, 70, 4);
    repeat (2000) step();
    knobs(1, 3, 0, 100, 0);
    repeat (30) step();
    chk("g_drained", exp_q.size(), 0);
    chk("g_mem_idle", mq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the branch-prediction table; it is the sole reader and writer of that table.
- Holds the PC, reads the predicted next PC combinationally from the table, and issues word-addressed requests to instruction memory.
- Buffers in-order responses and hands {pc, pred_pc, instr} to decode over valid/ready.
- On a redirect from execute, it flushes wrong-path work and writes the corrected target back into the table.

Parameters:
- DEPTH, 4, number of fetch-queue entries (power of 2, at least 2); this bounds in-flight plus buffered fetches.
- RESET_PC, 15'h0000, PC value loaded at reset (word address, bits [15:1]).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- bp_raddr  output  [15:1]  table read address; always equals pc.
- bp_rdata  input  [15:1]  predicted next PC; combinational, same cycle as bp_raddr.
- bp_wen  output  1  table write enable.
- bp_waddr  output  [15:1]  table write address.
- bp_wdata  output  [15:1]  table write data.
- imem_req_valid  output  1  fetch request.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  [15:1]  request word address; equals pc.
- imem_rsp_valid  input  1  response valid; responses return in order, latency 1 cycle or more.
- imem_rsp_data  input  [15:0]  instruction word.
- redirect_valid  input  1  mispredict or redirect pulse.
- redirect_src_pc  input  [15:1]  PC of the mispredicted instruction.
- redirect_target  input  [15:1]  correct next PC.
- out_valid  output  1  decode handoff valid.
- out_ready  input  1  decode accepts.
- out_pc  output  [15:1]  PC of the instruction.
- out_pred_pc  output  [15:1]  predicted next PC.
- out_instr  output  [15:0]  instruction word.

Behaviour:
- Reset values: pc=RESET_PC, queue empty, all kill bits 0, bp_wen=0, bp_waddr=0, bp_wdata=0.
  - Hence out_valid=0 and imem_req_valid=0 until the first cycle after reset release.
- Queue: circular buffer of DEPTH entries {pc, pred, instr, filled, kill}.
  - Three pointers: alloc_ptr, fill_ptr, rd_ptr.
  - count = entries allocated and not yet popped.
- Issue: imem_req_valid = (count < DEPTH) && !redirect_valid.
  - Requests are cancellable; memory must not rely on valid staying high.
  - On fire (valid && ready): allocate an entry {pc, bp_rdata, filled=0, kill=0} and set pc <= bp_rdata.
  - When ready=0: pc, bp_raddr and imem_req_addr hold.
- Response: imem_rsp_valid writes instr into the fill_ptr entry, sets filled=1 and advances fill_ptr.
  - A response with no unfilled entry outstanding is ignored (protocol violation; flagged by assertion).
- Output: out_valid = head filled && !head.kill && !redirect_valid.
  - out_* fields come from the head entry.
  - Pop occurs on out_valid && out_ready.
  - A filled head with kill=1 is popped silently in 1 cycle with no handoff.
- Redirect (redirect_valid=1, single-cycle pulse):
  - pc <= redirect_target; no request issues and no handoff occurs that cycle.
  - kill is set on every allocated entry; unfilled killed entries still consume their later responses, then drain silently.
  - Next cycle: bp_wen=1, bp_waddr=redirect_src_pc, bp_wdata=redirect_target, for exactly 1 cycle.
  - Back-to-back redirects are honoured each cycle; the last target wins.
- Same-cycle events:
  - response + redirect: the entry fills and is killed.
  - response + pop + issue: all take effect, and count updates by +1 -1.
- Full (count==DEPTH): no issue.
- Empty: out_valid=0.
- PC arithmetic is 15-bit, with no special casing at 15'h7fff.
- Best-case latency: request at cycle t, response at t+1, out_valid at t+2 (throughput 1 per cycle with a 1-cycle memory).
- Reset mid-operation clears all state immediately; responses arriving after reset with no entry outstanding are ignored.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_redirects [31:0] (redirect pulses) and perf_stall_cycles [31:0] (cycles with count==DEPTH).
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist.

Decomposition:
- fetch_pkg holds:
  - constants ADDR_W=15 and INSTR_W=16.
  - typedef fq_entry_t {pc, pred, instr, filled, kill}.
  - typedef addr_t (logic [15:1]).
- Sub-module fetch_queue: alloc/fill/pop/kill-all buffer exposing count, head and full. fetch_stage owns the PC, issue, redirect and table-write logic.

Test Plan:
- Reset with table in its default state (entry i holds i+1), 1-cycle memory returning instr={1'b0,addr}, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles; out_pred_pc=out_pc+1; no bubbles.
- Redirect src=15'h0005, target=15'h0100 -> next cycle bp_wen=1, bp_waddr=5, bp_wdata=15'h0100; no stale out_pc after the redirect; next out_pc=15'h0100; later fetch of pc 5 yields out_pred_pc=15'h0100.
- DEPTH=4, out_ready=0 -> exactly 4 requests fire, then imem_req_valid=0; raise out_ready -> 4 handoffs and fetch resumes at pc 4.
- imem_req_ready=0 for 5 cycles -> imem_req_addr and bp_raddr constant; no allocation.
- 3-cycle memory latency, redirect with 3 requests outstanding -> all 3 late responses dropped; out_valid stays 0 until the target's instruction arrives.
- RESET_PC=15'h7ffe -> out_pc 7ffe, 7fff, 0000 in order.
